sprite_read_arbiter: RTL and testbench

- Shares the single read port of one sprite frameRAM among NUM_REQ requesters, e.g. duck, dog and HUD draw logic all reading the same sprite.
- The RAM holds a 20x20 sprite: 400 entries, 1-cycle registered read.
- Round-robin arbitration; converts sprite-local (x,y) to a linear address; returns data tagged with requester id.
- Sits between the per-object draw units and frameRAM in the color-mapping path.

---
 rtl/sprite_read_arbiter.sv | 123 ++++++++++++
 tb/tb_sprite_read_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_read_arbiter.sv
// Round-robin arbiter sharing one sprite frameRAM read port among NUM_REQ draw units.
// Converts sprite-local (x,y) to a linear address and returns data tagged with requester id.
module sprite_read_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int SPR_W   = 20,
    parameter int SPR_H   = 20,
    parameter int ID_W    = 3
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*5-1:0]   req_x,
    input  logic [NUM_REQ*5-1:0]   req_y,
    input  logic                   hold,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [18:0]            ram_read_address,
    input  logic [4:0]             ram_data_out,
    output logic                   rd_valid,
    output logic [ID_W-1:0]        rd_id,
    output logic [4:0]             rd_data
);

    logic [ID_W-1:0]    rr_ptr_r;
    logic               found_s;
    int                 win_idx_s;
    int                 scan_idx_s;
    logic [ID_W-1:0]    win_s;
    logic [NUM_REQ-1:0] onehot_s;
    logic [4:0]         x_s;
    logic [4:0]         y_s;
    logic               oob_s;
    logic [18:0]        addr_s;
    logic               grant_s;

    logic [NUM_REQ-1:0] gnt_r;
    logic [18:0]        addr_r;
    logic [ID_W-1:0]    tag_r;
    logic               tag_oob_r;
    logic               rd_valid_r;
    logic [ID_W-1:0]    rd_id_r;
    logic               rd_oob_r;

    // Round-robin scan starting just after the last winner.
    always_comb begin
        found_s    = 1'b0;
        win_idx_s  = 0;
        scan_idx_s = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx_s = (int'(rr_ptr_r) + k) % NUM_REQ;
            if (!found_s && req[scan_idx_s]) begin
                found_s   = 1'b1;
                win_idx_s = scan_idx_s;
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Winner's coordinates, range check and linear address.
    always_comb begin
        win_s               = ID_W'(win_idx_s);
        onehot_s            = '0;
        onehot_s[win_idx_s] = 1'b1;
        x_s                 = req_x[win_idx_s*5 +: 5];
        y_s                 = req_y[win_idx_s*5 +: 5];
        oob_s               = (int'(x_s) >= SPR_W) || (int'(y_s) >= SPR_H);
        if (oob_s) begin
            addr_s = 19'd0;
        end else begin
            addr_s = 19'(y_s) * 19'(SPR_W) + 19'(x_s);
        end
        grant_s             = found_s && !hold;
    end

    // Grant stage: one-hot grant pulse, RAM address and pending tag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            gnt_r     <= '0;
            addr_r    <= 19'd0;
            rr_ptr_r  <= ID_W'(NUM_REQ - 1);
            tag_r     <= '0;
            tag_oob_r <= 1'b0;
        end else if (grant_s) begin
            gnt_r     <= onehot_s;
            addr_r    <= addr_s;
            rr_ptr_r  <= win_s;
            tag_r     <= win_s;
            tag_oob_r <= oob_s;
        end else begin
            gnt_r     <= '0;
        end
    end

    // Return stage: tag lines up with the RAM's registered read data.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_valid_r <= 1'b0;
            rd_id_r    <= '0;
            rd_oob_r   <= 1'b0;
        end else begin
            rd_valid_r <= |gnt_r;
            if (|gnt_r) begin
                rd_id_r  <= tag_r;
                rd_oob_r <= tag_oob_r;
            end
        end
    end

    // Out-of-range reads and idle cycles return the transparent index 0.
    always_comb begin
        if (rd_valid_r && !rd_oob_r) begin
            rd_data = ram_data_out;
        end else begin
            rd_data = 5'd0;
        end
    end

    assign gnt              = gnt_r;
    assign ram_read_address = addr_r;
    assign rd_valid         = rd_valid_r;
    assign rd_id            = rd_id_r;

endmodule

// File: tb/tb_sprite_read_arbiter.sv
// Scoreboard bench for sprite_read_arbiter with a behavioural 1-cycle frameRAM.
module tb_sprite_read_arbiter;

    localparam int N = 3;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic [N-1:0]  req;
    logic [N*5-1:0] req_x;
    logic [N*5-1:0] req_y;
    logic          hold;
    logic [N-1:0]  gnt;
    logic [18:0]   ram_read_address;
    logic [4:0]    ram_data_out;
    logic          rd_valid;
    logic [2:0]    rd_id;
    logic [4:0]    rd_data;

    typedef struct packed { logic [2:0] g; logic [18:0] a; } gexp_t;
    typedef struct packed { logic [2:0] id; logic [4:0] d; } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    gcq[$];
    gexp_t ge;
    rexp_t re;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    sprite_read_arbiter #(.NUM_REQ(N), .SPR_W(20), .SPR_H(20), .ID_W(3)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .req(req), .req_x(req_x), .req_y(req_y),
        .hold(hold), .gnt(gnt), .ram_read_address(ram_read_address),
        .ram_data_out(ram_data_out), .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data)
    );

    always #5 Clk = ~Clk;

    function automatic logic [4:0] ram_val(input logic [18:0] a);
        return 5'((int'(a) * 7 + 3) % 32);
    endfunction

    // Sprite RAM contents are a fixed function of the address; registered read.
    always @(posedge Clk) begin
        cyc          <= cyc + 1;
        ram_data_out <= ram_val(ram_read_address);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or read data.
    always @(negedge Clk) begin
        if (!Reset_n) begin
            gcq.delete();
        end else begin
            if (gnt !== '0) begin
                if (gq.size() == 0) begin
                    check("unexpected_gnt", 32'(gnt), 32'd0);
                end else begin
                    ge = gq.pop_front();
                    check("gnt", 32'(gnt), 32'(ge.g));
                    check("addr", 32'(ram_read_address), 32'(ge.a));
                    gcq.push_back(cyc);
                end
            end
            if (rd_valid !== 1'b0) begin
                if (rq.size() == 0) begin
                    check("unexpected_rd", 32'(rd_valid), 32'd0);
                end else begin
                    re = rq.pop_front();
                    check("rd_id", 32'(rd_id), 32'(re.id));
                    check("rd_data", 32'(rd_data), 32'(re.d));
                    if (gcq.size() == 0) check("rd_without_gnt", 32'(gcq.size()), 32'd1);
                    else check("rd_latency", 32'(cyc), 32'(gcq.pop_front() + 1));
                end
            end
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_xy(input int i, input logic [4:0] x, input logic [4:0] y);
        req_x[i*5 +: 5] = x;
        req_y[i*5 +: 5] = y;
    endtask

    task automatic expect_rd(input logic [2:0] g, input logic [18:0] a, input logic [2:0] id,
                             input logic [4:0] d);
        gq.push_back('{g: g, a: a});
        rq.push_back('{id: id, d: d});
    endtask

    task automatic drain;
        for (int i = 0; i < 20 && (gq.size() != 0 || rq.size() != 0); i++) tick();
        check("drain_gnt_queue", 32'(gq.size()), 32'd0);
        check("drain_rd_queue", 32'(rq.size()), 32'd0);
    endtask

    task automatic do_reset;
        req     = '0;
        hold    = 1'b0;
        Reset_n = 1'b0;
        repeat (2) tick();
        Reset_n = 1'b1;
        tick();
    endtask

    initial begin
        Reset_n = 1'b0;
        req     = '0;
        hold    = 1'b0;
        req_x   = '0;
        req_y   = '0;
        #12;
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_addr", 32'(ram_read_address), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_id", 32'(rd_id), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        do_reset();

        // Single read: (3,2) -> 43.
        set_xy(0, 5'd3, 5'd2);
        req = 3'b001;
        expect_rd(3'b001, 19'd43, 3'd0, ram_val(19'd43));
        tick();
        req = 3'b000;
        drain();

        // All three held for six grants.
        do_reset();
        set_xy(0, 5'd1, 5'd0);
        set_xy(1, 5'd2, 5'd1);
        set_xy(2, 5'd0, 5'd3);
        for (int r = 0; r < 2; r++) begin
            expect_rd(3'b001, 19'd1,  3'd0, ram_val(19'd1));
            expect_rd(3'b010, 19'd22, 3'd1, ram_val(19'd22));
            expect_rd(3'b100, 19'd60, 3'd2, ram_val(19'd60));
        end
        req = 3'b111;
        repeat (6) tick();
        req = 3'b000;
        drain();

        // Corner and out-of-range coordinates.
        do_reset();
        set_xy(0, 5'd19, 5'd19);
        set_xy(1, 5'd20, 5'd0);
        expect_rd(3'b001, 19'd399, 3'd0, ram_val(19'd399));
        expect_rd(3'b010, 19'd0,   3'd1, 5'd0);
        req = 3'b011;
        tick();
        req = 3'b010;
        tick();
        req = 3'b000;
        drain();

        // Hold blocks grants; pointer frozen.
        do_reset();
        set_xy(1, 5'd4, 5'd1);
        set_xy(2, 5'd5, 5'd5);
        hold = 1'b1;
        req  = 3'b110;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_gnt", 32'(gnt), 32'd0);
        end
        expect_rd(3'b010, 19'd24,  3'd1, ram_val(19'd24));
        expect_rd(3'b100, 19'd105, 3'd2, ram_val(19'd105));
        hold = 1'b0;
        tick();
        req = 3'b100;
        tick();
        req = 3'b000;
        drain();

        // Reset while a read is in flight.
        do_reset();
        set_xy(0, 5'd3, 5'd2);
        set_xy(1, 5'd2, 5'd1);
        set_xy(2, 5'd0, 5'd3);
        req = 3'b001;
        gq.push_back('{g: 3'b001, a: 19'd43});
        tick();
        req = 3'b000;
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_inflight_rd_valid", 32'(rd_valid), 32'd0);
        end
        check("reset_inflight_gnt_seen", 32'(gq.size()), 32'd0);
        Reset_n = 1'b1;
        tick();
        tick();
        check("post_reset_rd_valid", 32'(rd_valid), 32'd0);
        expect_rd(3'b001, 19'd43, 3'd0, ram_val(19'd43));
        expect_rd(3'b010, 19'd22, 3'd1, ram_val(19'd22));
        expect_rd(3'b100, 19'd60, 3'd2, ram_val(19'd60));
        req = 3'b111;
        repeat (3) tick();
        req = 3'b000;
        drain();

        // Lone requester streams one grant per cycle: (7,9) -> 187.
        set_xy(2, 5'd7, 5'd9);
        for (int i = 0; i < 4; i++) expect_rd(3'b100, 19'd187, 3'd2, ram_val(19'd187));
        req = 3'b100;
        repeat (4) tick();
        req = 3'b000;
        drain();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
